// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo responder.
// Contents: RX/TX FSM state types, the data width and the bits_for()
// helper that sizes the bit-period timers.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT
  } uart_rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } uart_tx_state_t;

  // Smallest width able to count 0..n-1 (ceil(log2(n)), at least 1).
  function automatic int bits_for(input int n);
    int w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_echo_responder_if.sv
// Signal bundle of the UART echo responder.
// slave  : responder side (rx/tx_enable in; tx, rx_byte, rx_valid,
//          frame_err, overflow, fifo_level, tx_busy out).
// master : environment side, directions reversed.
// With UART_ECHO_OVF_CNT_EN defined the bundle also carries ovf_count[7:0].
interface uart_echo_responder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          rx;
  logic          tx;
  logic          tx_enable;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          frame_err;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  logic          tx_busy;
`ifdef UART_ECHO_OVF_CNT_EN
  logic [7:0]    ovf_count;

  modport slave (
    input  rx, tx_enable,
    output tx, rx_byte, rx_valid, frame_err, overflow, fifo_level, tx_busy, ovf_count
  );
  modport master (
    output rx, tx_enable,
    input  tx, rx_byte, rx_valid, frame_err, overflow, fifo_level, tx_busy, ovf_count
  );
`else
  modport slave (
    input  rx, tx_enable,
    output tx, rx_byte, rx_valid, frame_err, overflow, fifo_level, tx_busy
  );
  modport master (
    output rx, tx_enable,
    input  tx, rx_byte, rx_valid, frame_err, overflow, fifo_level, tx_busy
  );
`endif
endinterface

// File: rtl/uart_echo_fifo.sv
// Synchronous FIFO used as the echo buffer.
// Ports: clk, rst_n (sync, active-low); push_i/push_data_i write side;
// pop_i/pop_data_o read side (pop_data_o shows the head, first-word
// fall-through); full_o, empty_o, level_o status.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign push_ok_s  = push_i && (!full_o || pop_i);
  assign pop_ok_s   = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end UART responder: receives 8N1 bytes on bus.rx, buffers them and
// replays each one unchanged on bus.tx.
// Ports: clk, rst_n (sync, active-low), bus (uart_echo_responder_if.slave):
//   rx, tx_enable in; tx, rx_byte, rx_valid, frame_err, overflow,
//   fifo_level, tx_busy out.
// Optional: define UART_ECHO_OVF_CNT_EN to add the saturating 8-bit
// ovf_count output counting overflow pulses.
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_echo_responder_if.slave  bus
);
  localparam int TW = bits_for(CLKS_PER_BIT);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta_q, rx_s_q;
  uart_rx_state_t            rx_state_q;
  logic [TW-1:0]             rx_timer_q;
  logic [2:0]                rx_bit_q;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_byte_q;
  logic                      rx_valid_q, frame_err_q, overflow_q;

  uart_tx_state_t            tx_state_q;
  logic [TW-1:0]             tx_timer_q;
  logic [2:0]                tx_bit_q;
  logic [UART_DATA_BITS-1:0] tx_shift_q;
  logic                      tx_q, tx_busy_q;

  logic                      pop_s, full_s, empty_s;
  logic [UART_DATA_BITS-1:0] pop_data_s;
  logic [LW-1:0]             level_s;

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM: half-bit start qualification, then mid-bit sampling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q  <= R_IDLE;
      rx_timer_q  <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        R_IDLE: begin
          rx_timer_q <= '0;
          if (!rx_s_q) rx_state_q <= R_START;
        end
        R_START: begin
          if (rx_timer_q == HALF_LAST) begin
            rx_timer_q <= '0;
            rx_bit_q   <= 3'd0;
            // A start bit that is gone by mid-bit was a glitch.
            rx_state_q <= rx_s_q ? R_IDLE : R_DATA;
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        R_DATA: begin
          if (rx_timer_q == BIT_LAST) begin
            rx_timer_q <= '0;
            rx_shift_q <= {rx_s_q, rx_shift_q[UART_DATA_BITS-1:1]};
            if (rx_bit_q == IDX_LAST) rx_state_q <= R_STOP;
            else                      rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        R_STOP: begin
          if (rx_timer_q == BIT_LAST) begin
            rx_timer_q <= '0;
            if (rx_s_q) begin
              rx_byte_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              rx_state_q <= R_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= R_WAIT;
            end
          end else begin
            rx_timer_q <= rx_timer_q + TW'(1);
          end
        end
        R_WAIT: begin
          // Line must return high before a new start bit is accepted.
          if (rx_s_q) rx_state_q <= R_IDLE;
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  // The FIFO push happens in the cycle rx_valid is high.
  uart_echo_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rx_valid_q),
    .push_data_i (rx_byte_q),
    .pop_i       (pop_s),
    .pop_data_o  (pop_data_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .level_o     (level_s)
  );

  assign pop_s = (tx_state_q == T_IDLE) && bus.tx_enable && !empty_s;

  // Overflow flag: a good byte arrived with no room and no concurrent pop.
  always_ff @(posedge clk) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= rx_valid_q && full_s && !pop_s;
  end

  // Transmit FSM: pops the head on leaving T_IDLE, serialises 8N1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_timer_q <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          tx_q       <= 1'b1;
          tx_timer_q <= '0;
          if (pop_s) begin
            tx_shift_q <= pop_data_s;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= T_START;
          end
        end
        T_START: begin
          if (tx_timer_q == BIT_LAST) begin
            tx_timer_q <= '0;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= T_DATA;
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        T_DATA: begin
          if (tx_timer_q == BIT_LAST) begin
            tx_timer_q <= '0;
            if (tx_bit_q == IDX_LAST) begin
              tx_q       <= 1'b1;
              tx_state_q <= T_STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        T_STOP: begin
          if (tx_timer_q == BIT_LAST) begin
            // One T_IDLE cycle follows, giving the 1-cycle inter-frame gap.
            tx_timer_q <= '0;
            tx_busy_q  <= 1'b0;
            tx_state_q <= T_IDLE;
          end else begin
            tx_timer_q <= tx_timer_q + TW'(1);
          end
        end
        default: begin
          tx_q       <= 1'b1;
          tx_busy_q  <= 1'b0;
          tx_state_q <= T_IDLE;
        end
      endcase
    end
  end

`ifdef UART_ECHO_OVF_CNT_EN
  logic [7:0] ovf_count_q;

  // Saturating overflow event counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count_q <= 8'd0;
    end else if (overflow_q && (ovf_count_q != 8'hFF)) begin
      ovf_count_q <= ovf_count_q + 8'd1;
    end
  end

  assign bus.ovf_count = ovf_count_q;
`endif

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.rx_byte    = rx_byte_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_level = level_s;

endmodule
